// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg
//
// Shared core definitions for the memory-port arbiter.
//   - STARVE_LIMIT_DEFAULT : default cap on consecutive load/store grants while
//                            an instruction fetch is waiting.
//   - arb_state_t          : arbiter FSM state (also exported on the debug port).
//   - owner_t              : which requester owns the current/locked request.
//   - mem_cmd_t            : the control/data fields presented on the memory port.
// -----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

    localparam int STARVE_LIMIT_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_IF = 2'd1,
        WAIT_LS = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_t;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_cmd_t;

    // A fetch is always a full-word read: no write enable, no byte enables,
    // no write data.
    function automatic mem_cmd_t fetch_cmd(input logic [31:0] addr);
        mem_cmd_t c;
        c.we    = 1'b0;
        c.be    = 4'b0000;
        c.addr  = addr;
        c.wdata = 32'h0;
        return c;
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one memory port between an instruction-fetch requester (if_*) and a
// load/store requester (ls_*). At most one memory transaction is outstanding.
// Load/store is favoured, but after STARVE_LIMIT consecutive load/store grants
// taken while fetch was waiting, a pending fetch wins the next arbitration.
//
// Handshake: a request is presented on mem_req with its fields; it is accepted
// in the cycle where mem_req && mem_gnt are both high, and the owner's *_gnt
// pulses in that same cycle. While mem_req is high without mem_gnt the choice
// of owner and the presented fields are frozen. The response is the single
// cycle in which mem_rvalid is high while waiting; it is passed straight
// through to the owner's *_rvalid/*_rdata in that cycle.
//
// Ports
//   clk, rst_n                 : clock, synchronous active-low reset
//   if_req/if_addr             : fetch request (word address)
//   if_gnt/if_rvalid/if_rdata  : fetch accept, fetch data
//   ls_req/ls_we/ls_be/
//   ls_addr/ls_wdata           : load/store request
//   ls_gnt/ls_rvalid/ls_rdata  : load/store accept, load data or store ack
//   mem_req/mem_we/mem_be/
//   mem_addr/mem_wdata         : request to the memory port
//   mem_gnt/mem_rvalid/
//   mem_rdata                  : memory port accept and response
//   proto_err                  : sticky, response seen with nothing outstanding
//   dbg_state                  : current FSM state, for observation only
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,

    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [3:0]  ls_be,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_gnt,
    output logic        ls_rvalid,
    output logic [31:0] ls_rdata,

    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,

    output logic        proto_err,
    output arb_state_t  dbg_state
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    arb_state_t       r_state;
    logic             r_lock;         // a request is on the port, not yet granted
    owner_t           r_lock_owner;
    mem_cmd_t         r_lock_cmd;     // fields frozen while locked
    logic [CNT_W-1:0] r_starve_cnt;
    logic             r_proto_err;

    // ------------------------------------------------------------------
    // Arbitration (only meaningful in IDLE)
    // ------------------------------------------------------------------
    mem_cmd_t w_if_cmd;
    mem_cmd_t w_ls_cmd;
    mem_cmd_t w_cmd;
    owner_t   w_owner;
    logic     w_req;
    logic     w_accept;
    logic     w_if_wins;

    assign w_if_cmd = fetch_cmd(if_addr);
    assign w_ls_cmd = '{we: ls_we, be: ls_be, addr: ls_addr, wdata: ls_wdata};

    // Fetch overrides the load/store preference only once it has been
    // passed over STARVE_LIMIT times in a row.
    assign w_if_wins = if_req && (r_starve_cnt == CNT_MAX);

    always_comb begin
        w_owner = OWN_IF;
        w_req   = 1'b0;
        w_cmd   = '0;
        if (r_state == IDLE) begin
            if (r_lock) begin
                // Locked: the owner keeps the port for as long as it keeps
                // requesting; if it drops out, nothing is presented this
                // cycle and the lock clears so a fresh choice is made next.
                w_owner = r_lock_owner;
                w_req   = (r_lock_owner == OWN_LS) ? ls_req : if_req;
                w_cmd   = w_req ? r_lock_cmd : '0;
            end else if (ls_req && !w_if_wins) begin
                w_owner = OWN_LS;
                w_req   = 1'b1;
                w_cmd   = w_ls_cmd;
            end else if (if_req) begin
                w_owner = OWN_IF;
                w_req   = 1'b1;
                w_cmd   = w_if_cmd;
            end
        end
    end

    assign w_accept = w_req && mem_gnt;

    // ------------------------------------------------------------------
    // Outputs. Everything is gated by rst_n so the block reads all-zero
    // while reset is held, including before the first reset edge.
    // ------------------------------------------------------------------
    logic w_if_rv;
    logic w_ls_rv;

    assign w_if_rv = rst_n && (r_state == WAIT_IF) && mem_rvalid;
    assign w_ls_rv = rst_n && (r_state == WAIT_LS) && mem_rvalid;

    assign mem_req   = rst_n && w_req;
    assign mem_we    = rst_n && w_cmd.we;
    assign mem_be    = rst_n ? w_cmd.be    : 4'b0000;
    assign mem_addr  = rst_n ? w_cmd.addr  : 32'h0;
    assign mem_wdata = rst_n ? w_cmd.wdata : 32'h0;

    assign if_gnt    = rst_n && w_accept && (w_owner == OWN_IF);
    assign ls_gnt    = rst_n && w_accept && (w_owner == OWN_LS);

    assign if_rvalid = w_if_rv;
    assign if_rdata  = w_if_rv ? mem_rdata : 32'h0;
    assign ls_rvalid = w_ls_rv;
    assign ls_rdata  = w_ls_rv ? mem_rdata : 32'h0;

    assign proto_err = rst_n && r_proto_err;
    assign dbg_state = rst_n ? r_state : IDLE;

    // ------------------------------------------------------------------
    // FSM, lock, starvation counter, protocol error
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_lock       <= 1'b0;
            r_lock_owner <= OWN_IF;
            r_lock_cmd   <= '0;
            r_starve_cnt <= '0;
            r_proto_err  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    // A response with nothing outstanding is dropped but
                    // remembered.
                    if (mem_rvalid) begin
                        r_proto_err <= 1'b1;
                    end
                    if (w_accept) begin
                        r_lock  <= 1'b0;
                        r_state <= (w_owner == OWN_LS) ? WAIT_LS : WAIT_IF;
                        if (w_owner == OWN_IF) begin
                            r_starve_cnt <= '0;
                        end else if (if_req && (r_starve_cnt != CNT_MAX)) begin
                            r_starve_cnt <= r_starve_cnt + CNT_ONE;
                        end
                    end else if (w_req) begin
                        r_lock       <= 1'b1;
                        r_lock_owner <= w_owner;
                        r_lock_cmd   <= w_cmd;
                    end else begin
                        r_lock <= 1'b0;
                    end
                end
                WAIT_IF, WAIT_LS: begin
                    if (mem_rvalid) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int LIMIT = 4;

    // ------------------------------------------------------------------
    // Clock / signals
    // ------------------------------------------------------------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        ls_req, ls_we;
    logic [3:0]  ls_be;
    logic [31:0] ls_addr, ls_wdata;
    logic        ls_gnt, ls_rvalid;
    logic [31:0] ls_rdata;
    logic        mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;
    logic        proto_err;
    arb_state_t  dbg_state;

    mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_be(ls_be), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid),
        .ls_rdata(ls_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .proto_err(proto_err), .dbg_state(dbg_state)
    );

    // ------------------------------------------------------------------
    // Scoreboard counters
    // ------------------------------------------------------------------
    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // ------------------------------------------------------------------
    // Reference model: transaction-level view of the port.
    //   m_out  : -1 nothing outstanding, 0 fetch outstanding, 1 ls outstanding
    //   m_lock : -1 none, else requester whose ungranted request is held
    // ------------------------------------------------------------------
    int           m_out    = -1;
    int           m_lock   = -1;
    logic [68:0]  m_lock_cmd = '0;
    int           m_starve = 0;
    bit           m_perr   = 1'b0;

    task automatic model_check();
        logic [69:0] e_mem;
        logic [1:0]  e_gnt;
        logic [32:0] e_ifr, e_lsr;
        logic        e_perr;
        arb_state_t  e_st;
        int          owner;
        logic [68:0] cmd;
        owner = -1;
        cmd   = '0;
        e_mem = '0; e_gnt = '0; e_ifr = '0; e_lsr = '0; e_perr = 1'b0; e_st = IDLE;
        if (rst_n) begin
            e_perr = m_perr;
            e_st   = (m_out == -1) ? IDLE : ((m_out == 0) ? WAIT_IF : WAIT_LS);
            if (m_out == -1) begin
                if (m_lock != -1) begin
                    if ((m_lock == 1 && ls_req) || (m_lock == 0 && if_req)) begin
                        owner = m_lock;
                        cmd   = m_lock_cmd;
                    end
                end else if (ls_req && !(if_req && m_starve == LIMIT)) begin
                    owner = 1;
                    cmd   = {ls_we, ls_be, ls_addr, ls_wdata};
                end else if (if_req) begin
                    owner = 0;
                    cmd   = {1'b0, 4'b0000, if_addr, 32'h0};
                end
                e_mem = {owner != -1, cmd};
                e_gnt = {owner == 0 && mem_gnt, owner == 1 && mem_gnt};
            end else if (mem_rvalid) begin
                if (m_out == 0) e_ifr = {1'b1, mem_rdata};
                else            e_lsr = {1'b1, mem_rdata};
            end
        end

        chk("mem_cmd", 128'({mem_req, mem_we, mem_be, mem_addr, mem_wdata}), 128'(e_mem));
        chk("gnt", 128'({if_gnt, ls_gnt}), 128'(e_gnt));
        chk("if_resp", 128'({if_rvalid, if_rdata}), 128'(e_ifr));
        chk("ls_resp", 128'({ls_rvalid, ls_rdata}), 128'(e_lsr));
        chk("proto_err", 128'(proto_err), 128'(e_perr));
        chk("state", 128'(dbg_state), 128'(e_st));

        // advance model to the next cycle
        if (!rst_n) begin
            m_out = -1; m_lock = -1; m_starve = 0; m_perr = 1'b0;
        end else if (m_out == -1) begin
            if (mem_rvalid) m_perr = 1'b1;
            if (owner != -1 && mem_gnt) begin
                m_out  = owner;
                m_lock = -1;
                if (owner == 0) m_starve = 0;
                else if (if_req && m_starve < LIMIT) m_starve++;
            end else if (owner != -1) begin
                m_lock     = owner;
                m_lock_cmd = cmd;
            end else begin
                m_lock = -1;
            end
        end else if (mem_rvalid) begin
            m_out = -1;
        end
    endtask

    // Inputs are driven at posedge+1; model check at negedge.
    task automatic tick();
        @(negedge clk);
        model_check();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req = 0; if_addr = 0;
        ls_req = 0; ls_we = 0; ls_be = 0; ls_addr = 0; ls_wdata = 0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
    endtask

    string seq;

    initial begin
        rst_n = 0;
        idle_inputs();

        // Reset state
        tick();
        chk("reset_mem_req", 128'(mem_req), 128'(0));
        do_reset();

        // Single load, grant same cycle, data two cycles after grant
        ls_req = 1; ls_addr = 32'h100; mem_gnt = 1;
        #3;
        chk("ld_gnt", 128'({ls_gnt, if_gnt}), 128'(2'b10));
        chk("ld_addr", 128'(mem_addr), 128'(32'h100));
        tick();
        ls_req = 0; mem_gnt = 0;
        tick();
        mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
        #3;
        chk("ld_rdata", 128'({ls_rvalid, ls_rdata, if_rvalid}), 128'({1'b1, 32'hDEADBEEF, 1'b0}));
        tick();
        idle_inputs();
        tick();

        // Both requesting continuously, memory always granting
        do_reset();
        seq = "";
        for (int i = 0; i < 20; i++) begin
            if_req = 1; if_addr = 32'h1000 + 32'(i);
            ls_req = 1; ls_addr = 32'h2000 + 32'(i);
            mem_gnt = 1;
            mem_rvalid = (m_out != -1); mem_rdata = 32'(i);
            #3;
            if (ls_gnt) seq = {seq, "L"};
            if (if_gnt) seq = {seq, "I"};
            tick();
        end
        chk("starve_pattern", 128'(seq == "LLLLILLLLI"), 128'(1));
        idle_inputs();
        mem_rvalid = (m_out != -1);
        tick();
        idle_inputs();

        // Fetch held off three cycles; ls arrives mid-wait
        do_reset();
        for (int i = 0; i < 4; i++) begin
            if_req = 1; if_addr = 32'h40;
            ls_req = (i >= 1); ls_addr = 32'h300;
            mem_gnt = (i == 3);
            #3;
            chk("lock_addr", 128'(mem_addr), 128'(32'h40));
            if (i == 3) chk("lock_gnt", 128'({if_gnt, ls_gnt}), 128'(2'b10));
            tick();
        end
        idle_inputs();
        mem_rvalid = 1; mem_rdata = 32'h0BAD_F00D;
        #3;
        chk("if_rdata", 128'({if_rvalid, if_rdata}), 128'({1'b1, 32'h0BAD_F00D}));
        tick();
        idle_inputs();

        // Store
        ls_req = 1; ls_we = 1; ls_be = 4'b0011; ls_addr = 32'h80; ls_wdata = 32'h1234;
        mem_gnt = 1;
        #3;
        chk("st_fields", 128'({mem_we, mem_be, mem_wdata}), 128'({1'b1, 4'b0011, 32'h1234}));
        tick();
        idle_inputs();
        mem_rvalid = 1; mem_rdata = 32'h5;
        #3;
        chk("st_ack", 128'({ls_rvalid, ls_rdata}), 128'({1'b1, 32'h5}));
        tick();
        idle_inputs();

        // Stray response in IDLE: sticky error
        mem_rvalid = 1;
        tick();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            #3;
            chk("perr_sticky", 128'(proto_err), 128'(1));
            tick();
        end
        do_reset();
        #3;
        chk("perr_cleared", 128'(proto_err), 128'(0));

        // Reset while waiting for fetch data
        if_req = 1; if_addr = 32'h44; mem_gnt = 1;
        tick();
        idle_inputs();
        #3;
        chk("wait_if", 128'(dbg_state), 128'(WAIT_IF));
        rst_n = 0;
        tick();
        rst_n = 1; mem_rvalid = 1; mem_rdata = 32'h77;
        #3;
        chk("abandon_rv", 128'({if_rvalid, ls_rvalid, dbg_state}), 128'({1'b0, 1'b0, IDLE}));
        tick();
        idle_inputs();
        #3;
        chk("abandon_perr", 128'(proto_err), 128'(1));
        tick();

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rst_n      = ($urandom_range(0, 99) != 0);
            if_req     = ($urandom_range(0, 9) < 7);
            if_addr    = $urandom;
            ls_req     = ($urandom_range(0, 9) < 6);
            ls_we      = $urandom_range(0, 1) == 1;
            ls_be      = 4'($urandom_range(0, 15));
            ls_addr    = $urandom;
            ls_wdata   = $urandom;
            mem_gnt    = $urandom_range(0, 1) == 1;
            mem_rdata  = $urandom;
            if (m_out != -1) mem_rvalid = $urandom_range(0, 1) == 1;
            else             mem_rvalid = ($urandom_range(0, 39) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: maximum consecutive load/store grants while fetch waits.
REQ-002 SHALL have port clk, input, 1: sole clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n, input, 1: synchronous, active-low reset.
REQ-004 SHALL have ports if_req (input, 1, fetch request), if_addr (input, 32, fetch word address), if_gnt (output, 1, fetch accepted).
REQ-005 SHALL have ports if_rvalid (output, 1, fetch data valid) and if_rdata (output, 32, fetched instruction).
REQ-006 SHALL have ports ls_req (in, 1), ls_we (in, 1, store), ls_be (in, 4, byte enables), ls_addr (in, 32), ls_wdata (in, 32): load/store request.
REQ-007 SHALL have ports ls_gnt (out, 1), ls_rvalid (out, 1, load data or store ack), ls_rdata (out, 32).
REQ-008 SHALL have ports mem_req, mem_we, mem_be[4], mem_addr[32], mem_wdata[32] (outputs to the single memory port).
REQ-009 SHALL have ports mem_gnt (in, 1), mem_rvalid (in, 1), mem_rdata (in, 32) from the memory port.
REQ-010 SHALL have port proto_err, output, 1: sticky flag, mem_rvalid received with no transaction outstanding.

Function
REQ-011 SHALL implement FSM states IDLE, WAIT_IF, WAIT_LS; at most one memory transaction outstanding.
REQ-012 In IDLE, SHALL assert mem_req when if_req or ls_req is high, driving the selected requester's fields combinationally; mem_we/mem_be/mem_wdata SHALL be 0 for fetch.
REQ-013 Selection SHALL favour ls over if, except when starve_cnt == STARVE_LIMIT and if_req is high, when if SHALL win.
REQ-014 Once mem_req is asserted without mem_gnt, selection SHALL be locked until grant; mem_addr/mem_we/mem_be/mem_wdata SHALL remain stable.
REQ-015 On mem_req && mem_gnt, SHALL pulse the owner's gnt in that same cycle and move to WAIT_IF or WAIT_LS next cycle.
REQ-016 In WAIT_x, mem_req SHALL be 0; on mem_rvalid, SHALL forward mem_rdata to owner's rdata and assert owner's rvalid in the same cycle (zero-latency pass-through), then return to IDLE.
REQ-017 Store completion SHALL also be signalled by ls_rvalid on mem_rvalid; ls_rdata then carries mem_rdata unchanged.
REQ-018 Non-owner rvalid SHALL be 0; rdata of a non-asserted rvalid SHALL be 0.
REQ-019 starve_cnt (width clog2(STARVE_LIMIT+1)) SHALL increment on each ls grant while if_req is high, saturate at STARVE_LIMIT, and clear on any if grant.
REQ-020 starve_cnt SHALL be unchanged on an ls grant when if_req is low.
REQ-021 mem_rvalid in IDLE SHALL set proto_err and be ignored (no requester rvalid).
REQ-022 Requester dropping req before grant SHALL release the lock; the arbiter re-selects next cycle.
REQ-023 Back-to-back: a new request SHALL be presentable in the IDLE cycle immediately after rvalid; minimum 2 cycles per transaction.

Reset
REQ-024 With rst_n low at a clock edge, SHALL enter IDLE, clear starve_cnt, lock and proto_err.
REQ-025 All outputs SHALL read 0 during reset; mid-transaction reset SHALL abandon the outstanding transaction without rvalid to any requester.

Structure
REQ-026 State enum and STARVE_LIMIT default SHALL reside in the shared core package with the opcode/control definitions.
REQ-027 SHALL be a single module; no sub-modules.

Verification
REQ-028 ls_req only, ls_we=0, addr 0x100, mem_gnt same cycle, mem_rvalid 2 cycles later data 0xDEADBEEF -> ls_gnt cycle 0, ls_rvalid=1 ls_rdata=0xDEADBEEF, if_rvalid=0.
REQ-029 if_req and ls_req both high continuously, mem always granting -> 4 ls grants then 1 if grant, repeating pattern.
REQ-030 if_req addr 0x40, mem_gnt held low 3 cycles, ls_req rises cycle 1 -> mem_addr stays 0x40 until grant; if_gnt, not ls_gnt.
REQ-031 Store ls_we=1 be=4'b0011 wdata 0x1234 -> mem_we=1 mem_be=0011 mem_wdata=0x1234; ls_rvalid on mem_rvalid.
REQ-032 mem_rvalid pulsed in IDLE -> proto_err=1 and stays 1 until rst_n low.
REQ-033 rst_n low in WAIT_IF, then mem_rvalid after reset -> no if_rvalid, state IDLE, proto_err=1.
